// File: rtl/audio_mix_pkg.sv
// Shared types and constants for the multi-channel ROM sample mixer.
// Contents:
//   ch_state_t         per-channel playback state (IDLE / PLAY)
//   MIX_NUM_CH/DATA_W  default channel count and sample width
//   SUM_W              adder-tree width for the default configuration
//   SAT_MAX / SAT_MIN  signed output clamp limits for the default width
//   sum_width/sat_max/sat_min  the same derivations for any parameter set
package audio_mix_pkg;

  typedef enum logic {CH_IDLE = 1'b0, CH_PLAY = 1'b1} ch_state_t;

  localparam int MIX_NUM_CH = 4;
  localparam int MIX_DATA_W = 16;
  localparam int SUM_W      = MIX_DATA_W + $clog2(MIX_NUM_CH);
  localparam int SAT_MAX    = (2 ** (MIX_DATA_W - 1)) - 1;
  localparam int SAT_MIN    = -(2 ** (MIX_DATA_W - 1));

  // Enough headroom that summing nch full-scale samples can never wrap.
  function automatic int sum_width(input int dw, input int nch);
    return dw + $clog2(nch);
  endfunction

  function automatic int sat_max(input int dw);
    return (2 ** (dw - 1)) - 1;
  endfunction

  function automatic int sat_min(input int dw);
    return -(2 ** (dw - 1));
  endfunction

endpackage

// File: rtl/audio_channel_player.sv
// One playback channel: IDLE/PLAY FSM, ROM address counter, latched
// length/mode, one-shot done pulse and the registered attenuated sample.
// Ports:
//   clk, reset      clock, async active-high reset
//   sample_req      advance request from the codec side
//   start, stop     one-cycle control pulses (stop has priority)
//   loop_mode, len  mode and sample count, captured on start
//   att             live arithmetic right-shift applied to the sample
//   rom_data        sample at the current address
//   addr            registered ROM address
//   busy            channel in PLAY
//   done            one-cycle pulse after a one-shot finishes
//   contrib         attenuated sample captured on sample_req (0 when idle)
module audio_channel_player
  import audio_mix_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 17,
  parameter int ATT_W  = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_req,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_mode,
  input  logic [ADDR_W-1:0]        len,
  input  logic [ATT_W-1:0]         att,
  input  logic signed [DATA_W-1:0] rom_data,
  output logic [ADDR_W-1:0]        addr,
  output logic                     busy,
  output logic                     done,
  output logic signed [DATA_W-1:0] contrib
);

  ch_state_t         state, state_nxt;
  logic [ADDR_W-1:0] addr_nxt, len_q, len_nxt;
  logic              loop_q, loop_nxt, done_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= CH_IDLE;
      addr    <= '0;
      len_q   <= '0;
      loop_q  <= 1'b0;
      done    <= 1'b0;
      contrib <= '0;
    end else begin
      state  <= state_nxt;
      addr   <= addr_nxt;
      len_q  <= len_nxt;
      loop_q <= loop_nxt;
      done   <= done_nxt;
      // Uses state/data from before this edge, so a restart in the same
      // cycle still emits the sample at the old address.
      if (sample_req)
        contrib <= (state == CH_PLAY) ? (rom_data >>> att) : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    len_nxt   = len_q;
    loop_nxt  = loop_q;
    done_nxt  = 1'b0;
    if (stop) begin
      state_nxt = CH_IDLE;
      addr_nxt  = '0;
    end else if (start && (len != '0)) begin
      state_nxt = CH_PLAY;
      addr_nxt  = '0;
      len_nxt   = len;
      loop_nxt  = loop_mode;
    end else if (sample_req && (state == CH_PLAY)) begin
      // Wrap on the latched length only; the counter never reaches ADDR_W overflow.
      if (addr == len_q - ADDR_W'(1)) begin
        addr_nxt = '0;
        if (!loop_q) begin
          state_nxt = CH_IDLE;
          done_nxt  = 1'b1;
        end
      end else begin
        addr_nxt = addr + ADDR_W'(1);
      end
    end
  end

  assign busy = (state == CH_PLAY);

endmodule

// File: rtl/audio_sample_mixer.sv
// Multi-channel ROM sample player and saturating mixer.
// Ports:
//   clk, reset     clock, async active-high reset
//   sample_req     codec request pulse (>=3 cycles apart)
//   ch_start/stop  per-channel control pulses
//   ch_loop/len    per-channel mode and length (packed, ch0 in LSBs)
//   ch_att         per-channel attenuation shift
//   mute           zero the mixed output
//   rom_addr       per-channel ROM address (packed)
//   rom_data       per-channel ROM data (packed), one cycle latency
//   audio_output   mixed, saturated sample
//   out_valid      pulse when audio_output updates
//   ch_busy        per-channel PLAY
//   ch_done        per-channel one-shot completion pulse
module audio_sample_mixer
  import audio_mix_pkg::*;
#(
  parameter int NUM_CH = MIX_NUM_CH,
  parameter int DATA_W = MIX_DATA_W,
  parameter int ADDR_W = 17,
  parameter int ATT_W  = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_req,
  input  logic [NUM_CH-1:0]        ch_start,
  input  logic [NUM_CH-1:0]        ch_stop,
  input  logic [NUM_CH-1:0]        ch_loop,
  input  logic [NUM_CH*ADDR_W-1:0] ch_len,
  input  logic [NUM_CH*ATT_W-1:0]  ch_att,
  input  logic                     mute,
  output logic [NUM_CH*ADDR_W-1:0] rom_addr,
  input  logic [NUM_CH*DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0]        audio_output,
  output logic                     out_valid,
  output logic [NUM_CH-1:0]        ch_busy,
  output logic [NUM_CH-1:0]        ch_done
);

  localparam int SW = sum_width(DATA_W, NUM_CH);
  localparam logic signed [SW-1:0] SAT_HI = SW'(sat_max(DATA_W));
  localparam logic signed [SW-1:0] SAT_LO = SW'(sat_min(DATA_W));

  logic signed [DATA_W-1:0] contrib [NUM_CH];
  logic signed [SW-1:0]     sum;
  logic signed [DATA_W-1:0] sat_res;
  // [0]: contributions captured, [1]: output registered
  logic [1:0]               vld_pipe;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    audio_channel_player #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ATT_W(ATT_W)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .sample_req(sample_req),
      .start     (ch_start[i]),
      .stop      (ch_stop[i]),
      .loop_mode (ch_loop[i]),
      .len       (ch_len[i*ADDR_W +: ADDR_W]),
      .att       (ch_att[i*ATT_W +: ATT_W]),
      .rom_data  (rom_data[i*DATA_W +: DATA_W]),
      .addr      (rom_addr[i*ADDR_W +: ADDR_W]),
      .busy      (ch_busy[i]),
      .done      (ch_done[i]),
      .contrib   (contrib[i])
    );
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_CH; i++)
      sum = sum + {{(SW-DATA_W){contrib[i][DATA_W-1]}}, contrib[i]};
  end

  always_comb begin
    sat_res = sum[DATA_W-1:0];
    if (sum > SAT_HI)      sat_res = SAT_HI[DATA_W-1:0];
    else if (sum < SAT_LO) sat_res = SAT_LO[DATA_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe     <= '0;
      audio_output <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], sample_req};
      if (vld_pipe[0])
        audio_output <= mute ? '0 : sat_res;
    end
  end

  assign out_valid = vld_pipe[1];

endmodule

// File: tb/tb_audio_sample_mixer.sv
module tb_audio_sample_mixer;
  localparam int NUM_CH = 4, DATA_W = 16, ADDR_W = 17, ATT_W = 3;

  logic clk = 1'b0, reset = 1'b1, sample_req = 1'b0, mute = 1'b0;
  logic [NUM_CH-1:0] ch_start = '0, ch_stop = '0, ch_loop;
  logic [NUM_CH*ADDR_W-1:0] ch_len, rom_addr;
  logic [NUM_CH*ATT_W-1:0]  ch_att;
  logic [NUM_CH*DATA_W-1:0] rom_data = '0;
  logic [DATA_W-1:0]        audio_output;
  logic                     out_valid;
  logic [NUM_CH-1:0]        ch_busy, ch_done;

  logic [ADDR_W-1:0] len_cfg  [NUM_CH];
  logic              loop_cfg [NUM_CH];
  logic [ATT_W-1:0]  att_cfg  [NUM_CH];
  logic [15:0]       rom_base [NUM_CH];
  logic [15:0]       rom_step [NUM_CH];

  // reference model
  bit                m_play [NUM_CH];
  logic [ADDR_W-1:0] m_addr [NUM_CH];
  logic [ADDR_W-1:0] m_len  [NUM_CH];
  bit                m_loop [NUM_CH];
  int                m_done [NUM_CH];
  int                d_done [NUM_CH];
  logic [15:0]       sb [$];
  int                n_chk = 0, n_fail = 0;

  audio_sample_mixer #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ATT_W(ATT_W)) dut (
    .clk(clk), .reset(reset), .sample_req(sample_req), .ch_start(ch_start), .ch_stop(ch_stop),
    .ch_loop(ch_loop), .ch_len(ch_len), .ch_att(ch_att), .mute(mute), .rom_addr(rom_addr),
    .rom_data(rom_data), .audio_output(audio_output), .out_valid(out_valid),
    .ch_busy(ch_busy), .ch_done(ch_done)
  );

  always #5 clk = ~clk;

  always_comb begin
    ch_len  = '0;
    ch_att  = '0;
    ch_loop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_len[i*ADDR_W +: ADDR_W] = len_cfg[i];
      ch_att[i*ATT_W +: ATT_W]   = att_cfg[i];
      ch_loop[i]                 = loop_cfg[i];
    end
  end

  function automatic logic [15:0] rom_fn(input int ch, input logic [ADDR_W-1:0] a);
    return rom_base[ch] + rom_step[ch] * a[15:0];
  endfunction

  // ROM with one cycle read latency
  always @(posedge clk)
    for (int i = 0; i < NUM_CH; i++)
      rom_data[i*DATA_W +: DATA_W] <= rom_fn(i, rom_addr[i*ADDR_W +: ADDR_W]);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) begin
        if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 32'd1);
        else                chk("audio_out", 32'(audio_output), 32'(sb.pop_front()));
      end
      for (int i = 0; i < NUM_CH; i++)
        if (ch_done[i]) d_done[i]++;
    end
  end

  // One control/request cycle; with req, also checks out_valid timing.
  task automatic step(input bit req, input logic [NUM_CH-1:0] st, input logic [NUM_CH-1:0] sp);
    int s;
    logic signed [15:0] d;
    @(negedge clk);
    sample_req = req; ch_start = st; ch_stop = sp;
    if (req) begin
      s = 0;
      for (int i = 0; i < NUM_CH; i++)
        if (m_play[i]) begin
          d = rom_fn(i, m_addr[i]);
          s += int'(d >>> att_cfg[i]);
        end
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
      sb.push_back(mute ? 16'h0 : 16'(s));
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (sp[i]) begin
        m_play[i] = 0; m_addr[i] = '0;
      end else if (st[i] && len_cfg[i] != '0) begin
        m_play[i] = 1; m_addr[i] = '0; m_len[i] = len_cfg[i]; m_loop[i] = loop_cfg[i];
      end else if (req && m_play[i]) begin
        if (m_addr[i] == m_len[i] - 1'b1) begin
          m_addr[i] = '0;
          if (!m_loop[i]) begin m_play[i] = 0; m_done[i]++; end
        end else m_addr[i] = m_addr[i] + 1'b1;
      end
    end
    @(negedge clk);
    sample_req = 1'b0; ch_start = '0; ch_stop = '0;
    if (req) begin
      chk("vld_edge0", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("vld_edge1", 32'(out_valid), 32'd1);
      @(negedge clk);
      chk("vld_edge2", 32'(out_valid), 32'd0);
    end else @(negedge clk);
  endtask

  task automatic check_model();
    for (int i = 0; i < NUM_CH; i++) begin
      chk($sformatf("rom_addr%0d", i), 32'(rom_addr[i*ADDR_W +: ADDR_W]), 32'(m_addr[i]));
      chk($sformatf("busy%0d", i), 32'(ch_busy[i]), 32'(m_play[i]));
      chk($sformatf("done_cnt%0d", i), 32'(d_done[i]), 32'(m_done[i]));
    end
  endtask

  initial begin
    int seq [10] = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2};
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq [10] = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2};
    for (int i = 0; i < NUM_CH; i++) begin
      len_cfg[i] = '0; loop_cfg[i] = 0; att_cfg[i] = '0; rom_base[i] = '0; rom_step[i] = '0;
      m_play[i] = 0; m_addr[i] = '0; m_len[i] = '0; m_loop[i] = 0; m_done[i] = 0; d_done[i] = 0;
    end
    #23;
    chk("rst_addr", 32'(rom_addr == '0), 32'd1);
    chk("rst_busy", 32'(ch_busy), 32'd0);
    chk("rst_audio", 32'(audio_output), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_done", 32'(ch_done), 32'd0);
    @(negedge clk); reset = 1'b0;

    // loop wrap
    len_cfg[0] = 4; loop_cfg[0] = 1; rom_base[0] = 16'h0010; rom_step[0] = 16'h1;
    step(0, 4'b0001, 4'b0000);
    for (int k = 0; k < 10; k++) begin
      step(1, 4'b0000, 4'b0000);
      chk("loop_addr", 32'(rom_addr[ADDR_W-1:0]), 32'(seq[k]));
    end
    chk("loop_no_done", 32'(d_done[0]), 32'd0);
    step(0, 4'b0000, 4'b0001);

    // one-shot end
    len_cfg[1] = 3; loop_cfg[1] = 0; rom_base[1] = 16'h0100; rom_step[1] = 16'h0;
    step(0, 4'b0010, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      step(1, 4'b0000, 4'b0000);
      chk("oneshot_out", 32'(audio_output), 32'h0100);
    end
    chk("oneshot_busy", 32'(ch_busy[1]), 32'd0);
    chk("oneshot_done", 32'(d_done[1]), 32'd1);
    step(1, 4'b0000, 4'b0000);
    chk("oneshot_after", 32'(audio_output), 32'h0);
    check_model();

    // saturation
    for (int i = 0; i < NUM_CH; i++) begin
      len_cfg[i] = 8; loop_cfg[i] = 1; att_cfg[i] = '0; rom_base[i] = 16'h7000; rom_step[i] = '0;
    end
    step(0, 4'b1111, 4'b0000);
    step(1, 4'b0000, 4'b0000);
    chk("sat_pos", 32'(audio_output), 32'h7FFF);
    for (int i = 0; i < NUM_CH; i++) rom_base[i] = 16'h9000;
    step(0, 4'b0000, 4'b0000);
    step(1, 4'b0000, 4'b0000);
    chk("sat_neg", 32'(audio_output), 32'h8000);
    step(0, 4'b0000, 4'b1111);

    // attenuation and mute
    rom_base[0] = 16'h4000; att_cfg[0] = 2;
    step(0, 4'b0001, 4'b0000);
    step(1, 4'b0000, 4'b0000);
    chk("atten", 32'(audio_output), 32'h1000);
    mute = 1'b1;
    step(1, 4'b0000, 4'b0000);
    chk("mute0", 32'(audio_output), 32'h0);
    step(1, 4'b0000, 4'b0000);
    chk("mute1", 32'(audio_output), 32'h0);
    chk("mute_addr", 32'(rom_addr[ADDR_W-1:0]), 32'd3);
    check_model();
    mute = 1'b0; att_cfg[0] = '0;
    step(0, 4'b0000, 4'b0001);

    // start/stop collisions
    len_cfg[2] = 5;
    step(0, 4'b0100, 4'b0100);
    chk("start_stop", 32'(ch_busy[2]), 32'd0);
    len_cfg[0] = 20; rom_base[0] = 16'h0200; rom_step[0] = 16'h3;
    step(0, 4'b0001, 4'b0000);
    for (int k = 0; k < 5; k++) step(1, 4'b0000, 4'b0000);
    chk("pre_restart", 32'(rom_addr[ADDR_W-1:0]), 32'd5);
    step(1, 4'b0001, 4'b0000);
    chk("restart_addr", 32'(rom_addr[ADDR_W-1:0]), 32'd0);
    chk("restart_data", 32'(audio_output), 32'h020F);
    len_cfg[3] = 0;
    step(0, 4'b1000, 4'b0000);
    chk("len0_busy", 32'(ch_busy[3]), 32'd0);
    check_model();

    // reset mid-playback at addr 37
    len_cfg[0] = 100; loop_cfg[0] = 1; rom_base[0] = 16'h1234; rom_step[0] = '0;
    step(0, 4'b0001, 4'b0000);
    for (int k = 0; k < 37; k++) step(1, 4'b0000, 4'b0000);
    chk("mid_addr", 32'(rom_addr[ADDR_W-1:0]), 32'd37);
    chk("mid_audio", 32'(audio_output), 32'h1234);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("arst_addr", 32'(rom_addr == '0), 32'd1);
    chk("arst_busy", 32'(ch_busy), 32'd0);
    chk("arst_audio", 32'(audio_output), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < NUM_CH; i++) begin m_play[i] = 0; m_addr[i] = '0; end
    sb.delete();
    @(negedge clk); reset = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
